starfield_blend: RTL
====================

# starfield_blend

Pixel-path stage directly downstream of the starfield generator: consumes its per-pixel `sf_on`/`sf_star` and composites stars under the foreground video layer, producing final 8-bit RGB. Adds CPU-controlled star tint, a per-frame brightness fade controller and optional twinkle, all pipelined on the pixel enable. Sits between the starfield generator and the video output/scandoubler.

## Interface
Parameters:
- `FADE_STEP`, default 8'd4: brightness units the fade level moves per frame.
- `FRAME_BITS`, default 3: width of the twinkle frame counter (1..8).

Ports:
- `clk`  in  1  system clock. One clock; everything is synchronous to it.
- `rst_n`  in  1  reset; asynchronous assert, active-low. Already decided.
- `en`  in  1  pixel enable, same strobe that drives the starfield generator.
- `hblank`, `vblank`  in  1 each  blanking for the current pixel.
- `sf_on`  in  1  star present at this pixel.
- `sf_star`  in  8  star brightness.
- `fg_on`  in  1  foreground opaque at this pixel.
- `fg_r`, `fg_g`, `fg_b`  in  8 each  foreground colour.
- `addr`  in  2  CPU register address.
- `data_in`  in  8  CPU write data.
- `write`  in  1  CPU write strobe, one `clk` wide.
- `r`, `g`, `b`  out  8 each  composited colour.
- `hblank_out`, `vblank_out`  out  1 each  blanking delayed to match `r/g/b`.

## Operation
- Registers (written on any `clk` with `write`, independent of `en`):
  - addr 0 `tint[2:0]`: R/G/B channel enables for stars.
  - addr 1 `target[7:0]`: fade target level.
  - addr 2 `ctrl[0]`: twinkle enable.
  - addr 3: ignored.
- Frame event: rising edge of `vblank` sampled on an `en` cycle (previous-`vblank` register updated only when `en` is high).
- Fade FSM, evaluated only on a frame event. `level` is 8 bits.
  - `HOLD` (level == target).
  - `UP`: level = min(level+FADE_STEP, target), computed 9-bit, no wrap.
  - `DOWN`: level = max(level-FADE_STEP, target), no underflow.
  - State is re-derived every frame event from the current `level` and the `target` value held before that cycle. A write to `target` in the same cycle as the frame event takes effect at the next frame event.
- `frame_cnt` (FRAME_BITS wide) increments on each frame event and wraps to 0.
- Twinkle: when `ctrl[0]`=1 and `sf_star[FRAME_BITS-1:0] == frame_cnt`, the star is suppressed for that pixel.
- Star intensity `si = (sf_star * level) >> 8`: 16-bit product, upper byte. level 255 with star 255 gives 254.
- Pixel select, in priority order:
  1. Any blank: 0.
  2. `fg_on`: fg colour.
  3. Star visible (`sf_on` and not suppressed): each channel is `si` if its tint bit is set, else 0.
  4. Otherwise 0.

## Timing
- Two-stage pipeline advancing only on `en`.
  - S1 registers inputs, the product and the twinkle decision.
  - S2 registers the select result plus delayed blanking.
- Latency: 2 `en` strobes from input to `r/g/b`. With `en`=0 all pipeline registers hold.
- Reset values: `r/g/b`=0, `hblank_out`=`vblank_out`=1, level=0, target=0, tint=3'b111, ctrl=0, frame_cnt=0, FSM=`HOLD`, pipeline registers cleared with blank=1.
- Reset mid-frame clears everything immediately. After release the first frame event is the next `vblank` rise seen on `en`; a `vblank` already high at release does not count as an edge.
- `level` and `frame_cnt` change only on frame-event cycles, so they are stable across the visible area.

## Structure
- Package `starfield_pkg` holds the register addresses (`SF_BLEND_TINT`, `SF_BLEND_TARGET`, `SF_BLEND_CTRL`) and the fade state encoding.
- One sub-module, `starfield_fade`, contains the FSM, `level` and `frame_cnt`. Its inputs are the frame event and `target`; its outputs are `level` and `frame_cnt`.
- The rest (registers, multiply, select, pipeline) stays in `starfield_blend`.

## Test plan
- Reset: hold `rst_n`=0 with `en` toggling → `r/g/b`=0, blank outs=1. Release, drive a visible star at 255 with target 0 → output stays 0.
- Fade up: target=8'd10, FADE_STEP=4 → level goes 4, 8, 10, 10 over four frame events. Star 255 with tint 3'b100 gives r=3, 7, 9; g=b=0.
- Fade down/clamp: level 10, target 0 → level 6, 2, 0, 0. Write target in the frame-event cycle → the old target is used that frame.
- Priority and latency: `fg_on`=1 with fg=(0x12,0x34,0x56) and a star present → output equals fg exactly 2 `en` strobes later. With `hblank`=1 the output is 0; `en` gaps stall the output.
- Twinkle: ctrl=1, frame_cnt=5, star with `sf_star[2:0]`=5 → 0. After the next frame event (cnt 6) the same star is visible. ctrl=0 → never suppressed.
- Wrap: 8 frame events → frame_cnt returns to 0. `vblank` high at reset release → no increment until a fresh rise.

Source files
------------

// File: rtl/starfield_pkg.sv
// Shared definitions for the starfield blend stage.
//   - CPU register addresses for tint, fade target and control.
//   - Fade controller state encoding.
//   - Packed pixel/pipeline structures and their reset values.
package starfield_pkg;

    localparam logic [1:0] SF_BLEND_TINT   = 2'd0;
    localparam logic [1:0] SF_BLEND_TARGET = 2'd1;
    localparam logic [1:0] SF_BLEND_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        FADE_HOLD = 2'd0,
        FADE_UP   = 2'd1,
        FADE_DOWN = 2'd2
    } fade_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // First pipeline stage: registered inputs, star intensity and twinkle result.
    typedef struct packed {
        logic       hblank;
        logic       vblank;
        logic       fg_on;
        rgb_t       fg;
        logic       star_vis;
        logic [7:0] si;
    } s1_t;

    // Second pipeline stage: final colour plus matching blanking.
    typedef struct packed {
        logic hblank;
        logic vblank;
        rgb_t rgb;
    } out_t;

    localparam s1_t S1_RESET = '{
        hblank:   1'b1,
        vblank:   1'b1,
        fg_on:    1'b0,
        fg:       '0,
        star_vis: 1'b0,
        si:       8'd0
    };

    localparam out_t OUT_RESET = '{
        hblank: 1'b1,
        vblank: 1'b1,
        rgb:    '0
    };

endpackage

// File: rtl/starfield_fade.sv
// Per-frame brightness fade controller and twinkle frame counter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   frame_evt   - one-cycle strobe marking a frame boundary
//   target      - fade target level (value held before this cycle)
//   level       - current brightness level, moves FADE_STEP per frame
//   frame_cnt   - free-running frame counter, wraps at 2**FRAME_BITS
module starfield_fade
    import starfield_pkg::*;
#(
    parameter logic [7:0] FADE_STEP  = 8'd4,
    parameter int         FRAME_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_evt,
    input  logic [7:0]            target,
    output logic [7:0]            level,
    output logic [FRAME_BITS-1:0] frame_cnt
);

    fade_state_t           state_q, state_d;
    logic [7:0]            level_q, level_d;
    logic [FRAME_BITS-1:0] cnt_q, cnt_d;
    logic [8:0]            up_sum;
    logic [8:0]            down_diff;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        cnt_d     = cnt_q;
        // 9-bit arithmetic: bit 8 flags overflow on the way up and
        // underflow on the way down, so the clamp never sees a wrapped value.
        up_sum    = {1'b0, level_q} + {1'b0, FADE_STEP};
        down_diff = {1'b0, level_q} - {1'b0, FADE_STEP};

        if (frame_evt) begin
            cnt_d = cnt_q + FRAME_BITS'(1);

            // Direction is re-derived on every frame from the live level,
            // so a target change simply redirects the next step.
            if (level_q < target) begin
                state_d = FADE_UP;
            end else if (level_q > target) begin
                state_d = FADE_DOWN;
            end else begin
                state_d = FADE_HOLD;
            end

            case (state_d)
                FADE_UP:   level_d = (up_sum > {1'b0, target}) ? target : up_sum[7:0];
                FADE_DOWN: level_d = (down_diff[8] || (down_diff[7:0] < target))
                                     ? target : down_diff[7:0];
                default:   level_d = level_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FADE_HOLD;
            level_q <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level     = level_q;
    assign frame_cnt = cnt_q;

endmodule

// File: rtl/starfield_blend.sv
// Composites starfield pixels under the foreground layer to produce final RGB.
// Adds CPU star tint, per-frame fade (via starfield_fade) and optional twinkle.
// Two-stage pipeline advancing only on en; latency two en strobes.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   en                      - pixel enable
//   hblank, vblank          - blanking for the incoming pixel
//   sf_on, sf_star          - star present / star brightness
//   fg_on, fg_r/g/b         - foreground opaque flag and colour
//   addr, data_in, write    - CPU register port (tint, target, ctrl)
//   r, g, b                 - composited colour
//   hblank_out, vblank_out  - blanking aligned with r/g/b
module starfield_blend
    import starfield_pkg::*;
#(
    parameter logic [7:0] FADE_STEP  = 8'd4,
    parameter int         FRAME_BITS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       hblank,
    input  logic       vblank,
    input  logic       sf_on,
    input  logic [7:0] sf_star,
    input  logic       fg_on,
    input  logic [7:0] fg_r,
    input  logic [7:0] fg_g,
    input  logic [7:0] fg_b,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    input  logic       write,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       hblank_out,
    output logic       vblank_out
);

    logic [2:0]            tint_q, tint_d;
    logic [7:0]            target_q, target_d;
    logic                  ctrl_q, ctrl_d;
    logic                  vblank_prev_q, vblank_prev_d;
    s1_t                   s1_q, s1_d;
    out_t                  out_q, out_d;

    logic                  frame_evt;
    logic                  suppress;
    logic [7:0]            si;
    logic [7:0]            level;
    logic [FRAME_BITS-1:0] frame_cnt;
    rgb_t                  star_rgb;

    // Frame boundary: vblank rising, judged only on pixel strobes.
    assign frame_evt = en && vblank && !vblank_prev_q;

    starfield_fade #(
        .FADE_STEP  (FADE_STEP),
        .FRAME_BITS (FRAME_BITS)
    ) u_fade (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_evt (frame_evt),
        .target    (target_q),
        .level     (level),
        .frame_cnt (frame_cnt)
    );

    assign suppress = ctrl_q && (sf_star[FRAME_BITS-1:0] == frame_cnt);
    // Upper byte of the 16-bit star * level product.
    assign si       = 8'((16'(sf_star) * 16'(level)) >> 8);

    // Tint gates each channel of the stage-1 intensity; bit 2 is red.
    assign star_rgb = '{
        r: tint_q[2] ? s1_q.si : 8'd0,
        g: tint_q[1] ? s1_q.si : 8'd0,
        b: tint_q[0] ? s1_q.si : 8'd0
    };

    // CPU registers respond to write on any clock, independent of en.
    always_comb begin
        tint_d   = tint_q;
        target_d = target_q;
        ctrl_d   = ctrl_q;
        if (write) begin
            case (addr)
                SF_BLEND_TINT:   tint_d   = data_in[2:0];
                SF_BLEND_TARGET: target_d = data_in;
                SF_BLEND_CTRL:   ctrl_d   = data_in[0];
                default:         ;
            endcase
        end
    end

    // Pixel pipeline: everything holds while en is low.
    always_comb begin
        vblank_prev_d = vblank_prev_q;
        s1_d          = s1_q;
        out_d         = out_q;
        if (en) begin
            vblank_prev_d = vblank;

            s1_d.hblank   = hblank;
            s1_d.vblank   = vblank;
            s1_d.fg_on    = fg_on;
            s1_d.fg       = '{r: fg_r, g: fg_g, b: fg_b};
            s1_d.star_vis = sf_on && !suppress;
            s1_d.si       = si;

            out_d.hblank  = s1_q.hblank;
            out_d.vblank  = s1_q.vblank;
            if (s1_q.hblank || s1_q.vblank) begin
                out_d.rgb = '0;
            end else if (s1_q.fg_on) begin
                out_d.rgb = s1_q.fg;
            end else if (s1_q.star_vis) begin
                out_d.rgb = star_rgb;
            end else begin
                out_d.rgb = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tint_q        <= 3'b111;
            target_q      <= 8'd0;
            ctrl_q        <= 1'b0;
            // Reset as "already high" so a vblank held through reset release
            // is not mistaken for a rising edge.
            vblank_prev_q <= 1'b1;
            s1_q          <= S1_RESET;
            out_q         <= OUT_RESET;
        end else begin
            tint_q        <= tint_d;
            target_q      <= target_d;
            ctrl_q        <= ctrl_d;
            vblank_prev_q <= vblank_prev_d;
            s1_q          <= s1_d;
            out_q         <= out_d;
        end
    end

    assign r          = out_q.rgb.r;
    assign g          = out_q.rgb.g;
    assign b          = out_q.rgb.b;
    assign hblank_out = out_q.hblank;
    assign vblank_out = out_q.vblank;

endmodule
